axi_gp_reg_slave: RTL and testbench

AXI3 slave register block hung directly off the PS7 M_AXI_GP0 master port: the first downstream stage consuming GP0 read/write transactions. It provides full read and write channels with INCR bursts up to 16 beats, four 32-bit registers, and drives the board LEDs from a control register. Replaces tie-off style slave logic so the processor can read and write the PL.

---
 rtl/axi_gp_pkg.sv | 29 ++
 rtl/axi_gp_reg_slave.sv | 217 +++++++++++++++++++++
 tb/tb_axi_gp_reg_slave.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_gp_pkg.sv
// Shared constants and FSM state types for the GP0 register slave.
package axi_gp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_LED     = 2'd0;
    localparam logic [1:0] REG_SCRATCH = 2'd1;
    localparam logic [1:0] REG_CNT     = 2'd2;
    localparam logic [1:0] REG_VER     = 2'd3;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    // A beat hits the register file only in the first 16 bytes and only if
    // the burst address never wrapped past 2^32.
    function automatic logic addr_in_range(input logic [31:0] addr, input logic wrapped);
        return (addr[31:4] == 28'd0) && !wrapped;
    endfunction

endpackage

// File: rtl/axi_gp_reg_slave.sv
// AXI3 register slave on PS7 M_AXI_GP0: four 32-bit registers, INCR bursts
// up to 16 beats, independent read and write channels, LEDs from reg0.
module axi_gp_reg_slave
    import axi_gp_pkg::*;
#(
    parameter int          ID_W      = 12,
    parameter logic [31:0] VERSION   = 32'h0001_0000,
    parameter logic [3:0]  LED_RESET = 4'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] s_axi_awid,
    input  logic [31:0]     s_axi_awaddr,
    input  logic [3:0]      s_axi_awlen,
    input  logic            s_axi_awvalid,
    output logic            s_axi_awready,
    input  logic [31:0]     s_axi_wdata,
    input  logic [3:0]      s_axi_wstrb,
    input  logic            s_axi_wlast,
    input  logic            s_axi_wvalid,
    output logic            s_axi_wready,
    output logic [ID_W-1:0] s_axi_bid,
    output logic [1:0]      s_axi_bresp,
    output logic            s_axi_bvalid,
    input  logic            s_axi_bready,
    input  logic [ID_W-1:0] s_axi_arid,
    input  logic [31:0]     s_axi_araddr,
    input  logic [3:0]      s_axi_arlen,
    input  logic            s_axi_arvalid,
    output logic            s_axi_arready,
    output logic [ID_W-1:0] s_axi_rid,
    output logic [31:0]     s_axi_rdata,
    output logic [1:0]      s_axi_rresp,
    output logic            s_axi_rlast,
    output logic            s_axi_rvalid,
    input  logic            s_axi_rready,
    output logic [3:0]      led
);

    logic [31:0] reg0;
    logic [31:0] reg1;
    logic [31:0] cnt;

    wstate_t     wstate;
    logic [31:0] w_addr;
    logic [3:0]  w_len;
    logic [3:0]  w_beat;
    logic        w_err;
    logic        w_wrap;

    rstate_t     rstate;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [3:0]  r_beat;
    logic        r_wrap;

    logic [32:0] w_addr_inc;
    logic [32:0] r_addr_inc;
    logic        w_ok;
    logic        r_nxt_wrap;

    assign led        = reg0[3:0];
    assign w_addr_inc = {1'b0, w_addr} + 33'd4;
    assign r_addr_inc = {1'b0, r_addr} + 33'd4;
    assign w_ok       = addr_in_range(w_addr, w_wrap);
    assign r_nxt_wrap = r_wrap | r_addr_inc[32];

    function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] reg_read(input logic [1:0] idx);
        case (idx)
            REG_LED:     return reg0;
            REG_SCRATCH: return reg1;
            REG_CNT:     return cnt;
            default:     return VERSION;
        endcase
    endfunction

    // Free-running cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= 32'd0;
        else     cnt <= cnt + 32'd1;
    end

    // Write FSM: address capture, per-beat register update, response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate        <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= RESP_OKAY;
            w_addr        <= 32'd0;
            w_len         <= 4'd0;
            w_beat        <= 4'd0;
            w_err         <= 1'b0;
            w_wrap        <= 1'b0;
            reg0          <= {28'd0, LED_RESET};
            reg1          <= 32'd0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (s_axi_awvalid) begin
                        s_axi_bid     <= s_axi_awid;
                        w_addr        <= s_axi_awaddr;
                        w_len         <= s_axi_awlen;
                        w_beat        <= 4'd0;
                        w_err         <= 1'b0;
                        w_wrap        <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        wstate        <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        if (w_ok && w_addr[3:2] == REG_LED)
                            reg0 <= merge_strb(reg0, s_axi_wdata, s_axi_wstrb);
                        if (w_ok && w_addr[3:2] == REG_SCRATCH)
                            reg1 <= merge_strb(reg1, s_axi_wdata, s_axi_wstrb);
                        w_addr <= w_addr_inc[31:0];
                        w_wrap <= w_wrap | w_addr_inc[32];
                        w_beat <= w_beat + 4'd1;
                        if (s_axi_wlast) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (w_err || !w_ok || w_beat != w_len)
                                            ? RESP_SLVERR : RESP_OKAY;
                            wstate       <= W_RESP;
                        end else begin
                            // A beat that should have been last but was not
                            // marks the burst as malformed, even if the beat
                            // counter later wraps back to len.
                            w_err <= w_err | !w_ok | (w_beat == w_len);
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        wstate        <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: one-cycle AR-to-R latency, one beat per clock sustained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate        <= R_IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= 32'd0;
            s_axi_rresp   <= RESP_OKAY;
            r_addr        <= 32'd0;
            r_len         <= 4'd0;
            r_beat        <= 4'd0;
            r_wrap        <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        s_axi_rid     <= s_axi_arid;
                        r_addr        <= s_axi_araddr;
                        r_len         <= s_axi_arlen;
                        r_beat        <= 4'd0;
                        r_wrap        <= 1'b0;
                        s_axi_rdata   <= addr_in_range(s_axi_araddr, 1'b0)
                                         ? reg_read(s_axi_araddr[3:2]) : 32'd0;
                        s_axi_rresp   <= addr_in_range(s_axi_araddr, 1'b0)
                                         ? RESP_OKAY : RESP_SLVERR;
                        s_axi_rlast   <= (s_axi_arlen == 4'd0);
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        rstate        <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            rstate        <= R_IDLE;
                        end else begin
                            r_addr      <= r_addr_inc[31:0];
                            r_wrap      <= r_nxt_wrap;
                            r_beat      <= r_beat + 4'd1;
                            s_axi_rlast <= ((r_beat + 4'd1) == r_len);
                            s_axi_rdata <= addr_in_range(r_addr_inc[31:0], r_nxt_wrap)
                                           ? reg_read(r_addr_inc[3:2]) : 32'd0;
                            s_axi_rresp <= addr_in_range(r_addr_inc[31:0], r_nxt_wrap)
                                           ? RESP_OKAY : RESP_SLVERR;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_gp_reg_slave.sv
// Directed bench for the GP0 register slave.
module tb_axi_gp_reg_slave;

    localparam int          ID_W    = 12;
    localparam logic [31:0] VERSION = 32'h0001_0000;
    localparam int          BOUND   = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [3:0]      led;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] tb_cnt;
    logic [31:0] snap;
    logic [31:0] dummy;

    always #5 clk = ~clk;

    // Reference cycle counter: cleared by reset, +1 on every clock.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 32'd0;
        else     tb_cnt <= tb_cnt + 32'd1;
    end

    axi_gp_reg_slave #(.ID_W(ID_W), .VERSION(VERSION), .LED_RESET(4'h0)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .led(led)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len);
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        for (int i = 0; i < BOUND && !awready; i++) tick();
        chk("awready_wait", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic last);
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        for (int i = 0; i < BOUND && !wready; i++) tick();
        chk("wready_wait", {31'd0, wready}, 32'd1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic get_b(input logic [ID_W-1:0] exp_id, input logic [1:0] exp_resp, input int hold);
        bready = 1'b0;
        for (int i = 0; i < BOUND && !bvalid; i++) tick();
        chk("bvalid_wait", {31'd0, bvalid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
        end
        chk("bid", {20'd0, bid}, {20'd0, exp_id});
        chk("bresp", {30'd0, bresp}, {30'd0, exp_resp});
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clear", {31'd0, bvalid}, 32'd0);
        chk("awready_after_b", {31'd0, awready}, 32'd1);
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len);
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        for (int i = 0; i < BOUND && !arready; i++) tick();
        chk("arready_wait", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        chk("rvalid_latency", {31'd0, rvalid}, 32'd1);
    endtask

    // Accepts one R beat; cnt_hs is the counter value at the handshake edge,
    // which is what the following beat will carry if it addresses reg2.
    task automatic rbeat(input logic [ID_W-1:0] exp_id, input logic [31:0] exp_d,
                         input logic [1:0] exp_resp, input logic exp_last,
                         output logic [31:0] cnt_hs);
        rready = 1'b1;
        for (int i = 0; i < BOUND && !rvalid; i++) tick();
        chk("rvalid_wait", {31'd0, rvalid}, 32'd1);
        chk("rid", {20'd0, rid}, {20'd0, exp_id});
        chk("rdata", rdata, exp_d);
        chk("rresp", {30'd0, rresp}, {30'd0, exp_resp});
        chk("rlast", {31'd0, rlast}, {31'd0, exp_last});
        cnt_hs = tb_cnt;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();

        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_led", {28'd0, led}, 32'd0);
        rst = 1'b0;
        tick();

        // Single write to LED register
        send_aw(12'h123, 32'h0, 4'd0);
        wbeat(32'hA, 4'hF, 1'b1);
        chk("led_single", {28'd0, led}, 32'hA);
        get_b(12'h123, 2'b00, 0);

        // 4-beat write walks reg0..reg3; RO targets ignored
        send_aw(12'h005, 32'h0, 4'd3);
        wbeat(32'd1, 4'hF, 1'b0);
        wbeat(32'd2, 4'hF, 1'b0);
        wbeat(32'd3, 4'hF, 1'b0);
        wbeat(32'd4, 4'hF, 1'b1);
        get_b(12'h005, 2'b00, 0);
        chk("led_burst", {28'd0, led}, 32'h1);

        // 4-beat read back
        send_ar(12'h07A, 32'h0, 4'd3);
        rbeat(12'h07A, 32'd1, 2'b00, 1'b0, dummy);
        rbeat(12'h07A, 32'd2, 2'b00, 1'b0, snap);
        rbeat(12'h07A, snap, 2'b00, 1'b0, dummy);
        rbeat(12'h07A, VERSION, 2'b00, 1'b1, dummy);
        chk("arready_after_r", {31'd0, arready}, 32'd1);
        chk("rvalid_after_r", {31'd0, rvalid}, 32'd0);

        // Byte strobe on scratch
        send_aw(12'h010, 32'h4, 4'd0);
        wbeat(32'h0, 4'hF, 1'b1);
        get_b(12'h010, 2'b00, 0);
        send_aw(12'h011, 32'h4, 4'd0);
        wbeat(32'hFFFF_FFFF, 4'h2, 1'b1);
        get_b(12'h011, 2'b00, 0);
        send_ar(12'h020, 32'h7, 4'd0);
        rbeat(12'h020, 32'h0000_FF00, 2'b00, 1'b1, dummy);

        // Out-of-range read and write
        send_ar(12'h030, 32'h10, 4'd1);
        rbeat(12'h030, 32'h0, 2'b10, 1'b0, dummy);
        rbeat(12'h030, 32'h0, 2'b10, 1'b1, dummy);
        send_aw(12'h031, 32'h10, 4'd0);
        wbeat(32'hDEAD_BEEF, 4'hF, 1'b1);
        get_b(12'h031, 2'b10, 0);
        send_ar(12'h032, 32'h0, 4'd1);
        rbeat(12'h032, 32'd1, 2'b00, 1'b0, dummy);
        rbeat(12'h032, 32'h0000_FF00, 2'b00, 1'b1, dummy);

        // Early wlast (len=3, last on beat 2) with stalled bready
        send_aw(12'h040, 32'h8, 4'd3);
        wbeat(32'h5555_5555, 4'hF, 1'b0);
        wbeat(32'h6666_6666, 4'hF, 1'b1);
        get_b(12'h040, 2'b10, 5);

        // R stall mid-burst
        send_ar(12'h050, 32'h0, 4'd3);
        rbeat(12'h050, 32'd1, 2'b00, 1'b0, dummy);
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rvalid", {31'd0, rvalid}, 32'd1);
            chk("stall_rdata", rdata, 32'h0000_FF00);
            chk("stall_rlast", {31'd0, rlast}, 32'd0);
        end
        rbeat(12'h050, 32'h0000_FF00, 2'b00, 1'b0, snap);
        rbeat(12'h050, snap, 2'b00, 1'b0, dummy);
        rbeat(12'h050, VERSION, 2'b00, 1'b1, dummy);

        // Reset mid-burst
        send_ar(12'h060, 32'h0, 4'd3);
        rbeat(12'h060, 32'd1, 2'b00, 1'b0, dummy);
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("midrst_arready", {31'd0, arready}, 32'd1);
        chk("midrst_led", {28'd0, led}, 32'h0);
        chk("midrst_rlast", {31'd0, rlast}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_rvalid", {31'd0, rvalid}, 32'd0);
        send_ar(12'h070, 32'h4, 4'd0);
        rbeat(12'h070, 32'h0, 2'b00, 1'b1, dummy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
